// File: rtl/mem_wb_skid_pkg.sv
// Shared types and constants for the MEM/WB skid stage.
package mem_wb_skid_pkg;

  // Register-file side widths and idle values.
  localparam int          REG_ADDR_W    = 5;
  localparam int          REG_DATA_W    = 32;
  localparam logic [4:0]  NOP_REG_ADDR  = 5'd0;
  localparam logic [31:0] ZERO_WORD     = 32'd0;
  localparam logic        WRITE_DISABLE = 1'b0;

  // Occupancy of the two-slot buffer; the encoding mirrors {skid_valid, main_valid}.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } skid_state_e;

endpackage

// File: rtl/mem_wb_skid_if.sv
// Valid/ready register-write bundle carrying LANES write lanes.
// Optional PC tracking when MEM_WB_DEBUG_PC_EN is defined.
interface mem_wb_skid_if
  import mem_wb_skid_pkg::*;
#(
  parameter int LANES  = 1,
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
);
  logic                      valid;
  logic                      ready;
  logic [LANES*ADDR_W-1:0]   waddr;
  logic [LANES-1:0]          we;
  logic [LANES*DATA_W-1:0]   wdata;
`ifdef MEM_WB_DEBUG_PC_EN
  logic [31:0]               debug_pc;

  modport master (output valid, waddr, we, wdata, debug_pc, input ready);
  modport slave  (input  valid, waddr, we, wdata, debug_pc, output ready);
`else
  modport master (output valid, waddr, we, wdata, input ready);
  modport slave  (input  valid, waddr, we, wdata, output ready);
`endif
endinterface

// File: rtl/mem_wb_skid_slot.sv
// One buffer slot: valid bit plus LANES of write payload (and PC when
// MEM_WB_DEBUG_PC_EN is defined). clear_i dominates load_i.
module mem_wb_slot
  import mem_wb_skid_pkg::*;
#(
  parameter int LANES  = 1,
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear_i,
  input  logic                    load_i,
  input  logic [LANES*ADDR_W-1:0] waddr_i,
  input  logic [LANES-1:0]        we_i,
  input  logic [LANES*DATA_W-1:0] wdata_i,
`ifdef MEM_WB_DEBUG_PC_EN
  input  logic [31:0]             pc_i,
  output logic [31:0]             pc_o,
`endif
  output logic                    valid_o,
  output logic [LANES*ADDR_W-1:0] waddr_o,
  output logic [LANES-1:0]        we_o,
  output logic [LANES*DATA_W-1:0] wdata_o
);

  logic                    valid_q;
  logic [LANES*ADDR_W-1:0] waddr_q;
  logic [LANES-1:0]        we_q;
  logic [LANES*DATA_W-1:0] wdata_q;
  logic                    pay_load;

  assign pay_load = load_i & ~clear_i;

  // Occupancy bit: clear wins, load sets, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n)       valid_q <= 1'b0;
    else if (clear_i) valid_q <= 1'b0;
    else if (load_i)  valid_q <= 1'b1;
  end

  // Payload: loads only on its enable, otherwise keeps stale contents.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: payload is reset because wb_waddr/wb_wdata must read idle values out of reset.
    if (!rst_n) begin
      waddr_q <= {LANES{ADDR_W'(NOP_REG_ADDR)}};
      we_q    <= {LANES{WRITE_DISABLE}};
      wdata_q <= {LANES{DATA_W'(ZERO_WORD)}};
    end else if (pay_load) begin
      waddr_q <= waddr_i;
      we_q    <= we_i;
      wdata_q <= wdata_i;
    end
  end

`ifdef MEM_WB_DEBUG_PC_EN
  logic [31:0] pc_q;

  // PC travels with its entry under the same load enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        pc_q <= ZERO_WORD;
    else if (pay_load) pc_q <= pc_i;
  end

  assign pc_o = pc_q;
`endif

  assign valid_o = valid_q;
  assign waddr_o = waddr_q;
  assign we_o    = we_q;
  assign wdata_o = wdata_q;

endmodule

// File: rtl/mem_wb_skid.sv
// MEM/WB pipeline stage with valid/ready handshake and a 2-entry skid
// buffer (MAIN drives writeback, SKID absorbs one cycle of back-pressure).
// Optional feature macro: MEM_WB_DEBUG_PC_EN (carries the instruction PC).
module mem_wb_skid
  import mem_wb_skid_pkg::*;
#(
  parameter int LANES  = 1,
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic          clk,
  input  logic          rst,      // asynchronous, active-low
  input  logic          flush,
  mem_wb_skid_if.slave  mem,
  mem_wb_skid_if.master wb
);

  skid_state_e state_q, state_d;

  logic main_valid, main_load, main_clear, main_from_skid;
  logic skid_valid, skid_load, skid_clear;
  logic in_fire, out_fire;

  logic [LANES*ADDR_W-1:0] main_waddr, skid_waddr, main_waddr_in;
  logic [LANES-1:0]        main_we, skid_we, main_we_in;
  logic [LANES*DATA_W-1:0] main_wdata, skid_wdata, main_wdata_in;

  // Ready depends only on registered occupancy, never on wb.ready.
  assign mem.ready = rst & ~skid_valid;
  assign wb.valid  = main_valid;
  assign in_fire   = mem.valid & mem.ready;
  assign out_fire  = main_valid & wb.ready;

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_EMPTY;
    else      state_q <= state_d;
  end

  // Next state and slot controls; flush overrides every transfer.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    state_d        = state_q;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      state_d    = ST_EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_load = 1'b1;
            state_d   = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            skid_load = 1'b1;
            state_d   = ST_FULL;
          end else if (out_fire) begin
            main_clear = 1'b1;
            state_d    = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
            state_d        = ST_ONE;
          end
        end
        default: begin
          main_clear = 1'b1;
          skid_clear = 1'b1;
          state_d    = ST_EMPTY;
        end
      endcase
    end
  end

  // MAIN refills from SKID when draining FULL, otherwise from upstream.
  assign main_waddr_in = main_from_skid ? skid_waddr : mem.waddr;
  assign main_we_in    = main_from_skid ? skid_we    : mem.we;
  assign main_wdata_in = main_from_skid ? skid_wdata : mem.wdata;

`ifdef MEM_WB_DEBUG_PC_EN
  logic [31:0] main_pc, skid_pc, main_pc_in;
  assign main_pc_in  = main_from_skid ? skid_pc : mem.debug_pc;
  assign wb.debug_pc = main_pc;
`endif

  mem_wb_slot #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_main (
    .clk     (clk),
    .rst_n   (rst),
    .clear_i (main_clear),
    .load_i  (main_load),
    .waddr_i (main_waddr_in),
    .we_i    (main_we_in),
    .wdata_i (main_wdata_in),
`ifdef MEM_WB_DEBUG_PC_EN
    .pc_i    (main_pc_in),
    .pc_o    (main_pc),
`endif
    .valid_o (main_valid),
    .waddr_o (main_waddr),
    .we_o    (main_we),
    .wdata_o (main_wdata)
  );

  mem_wb_slot #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_skid (
    .clk     (clk),
    .rst_n   (rst),
    .clear_i (skid_clear),
    .load_i  (skid_load),
    .waddr_i (mem.waddr),
    .we_i    (mem.we),
    .wdata_i (mem.wdata),
`ifdef MEM_WB_DEBUG_PC_EN
    .pc_i    (mem.debug_pc),
    .pc_o    (skid_pc),
`endif
    .valid_o (skid_valid),
    .waddr_o (skid_waddr),
    .we_o    (skid_we),
    .wdata_o (skid_wdata)
  );

  // Write strobes never escape an invalid MAIN slot.
  assign wb.we    = main_we & {LANES{main_valid}};
  assign wb.waddr = main_waddr;
  assign wb.wdata = main_wdata;

endmodule
